// File: rtl/random_clk_pkg.sv
// Shared types and helpers for the clock-stress data checker.
// The generator holds each value 0..MAX for HOLD cycles, with MAX = HOLD = VALIDATION_COUNT + 1.
package random_clk_pkg;

    typedef enum logic [1:0] {
        ACQUIRE = 2'd0,
        SYNC    = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } checker_state_e;

    // Number of cycles the generator holds each value.
    function automatic int unsigned hold_len(input int unsigned validation_count);
        return validation_count + 1;
    endfunction

    // Top value of the stepped counter; the value after it is 0.
    function automatic int unsigned max_val(input int unsigned validation_count);
        return validation_count + 1;
    endfunction

    // The run counter saturates at HOLD+1, so it needs values 0..HOLD+1.
    function automatic int unsigned run_cnt_width(input int unsigned validation_count);
        return $clog2(hold_len(validation_count) + 2);
    endfunction

endpackage

// File: rtl/seq_run_tracker.sv
// Tracks the last sample and how long it has been held, and classifies each new sample
// against it. The outputs are combinational; the checker top registers its own outputs.
module seq_run_tracker
    import random_clk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned VALIDATION_COUNT = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data,
    output logic                  good_transition,
    output logic                  bad_transition,
    output logic                  run_len_ok,
    output logic                  stuck
);

    localparam int unsigned           HOLD     = hold_len(VALIDATION_COUNT);
    localparam int unsigned           RUN_W    = run_cnt_width(VALIDATION_COUNT);
    localparam logic [DATA_WIDTH-1:0] MAX_D    = DATA_WIDTH'(max_val(VALIDATION_COUNT));
    localparam logic [RUN_W-1:0]      RUN_HOLD = RUN_W'(HOLD);
    localparam logic [RUN_W-1:0]      RUN_SAT  = RUN_W'(HOLD + 1);

    logic [DATA_WIDTH-1:0] d_prev;
    logic [DATA_WIDTH-1:0] next_val;
    logic [RUN_W-1:0]      r_run;
    logic                  same;

    // Classify the incoming sample against the previous one.
    always_comb begin
        next_val        = (d_prev == MAX_D) ? '0 : d_prev + DATA_WIDTH'(1);
        same            = (data == d_prev);
        // Both ends must be in range; this also stops an all-ones value wrapping to 0.
        good_transition = !same && (d_prev <= MAX_D) && (data <= MAX_D) && (data == next_val);
        bad_transition  = !same && !good_transition;
        run_len_ok      = (r_run == RUN_HOLD);
        stuck           = same && run_len_ok;
    end

    // Track the last sample and its run length; any change starts a new run of one.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_prev <= '0;
            r_run  <= '0;
        end else begin
            d_prev <= data;
            if (same) begin
                if (r_run != RUN_SAT) begin
                    r_run <= r_run + RUN_W'(1);
                end
            end else begin
                r_run <= RUN_W'(1);
            end
        end
    end

endmodule

// File: rtl/random_clk_data_checker.sv
// Receive-side checker for the stepped counter stream of the clock-stress generator.
// Locks onto the stream after LOCK_RUNS good runs, then flags and counts violations.
// Optional macro CHECKER_STICKY_FAULT_EN: a violation while locked parks the checker in a
// sticky FAULT state until reset instead of returning to acquisition.
module random_clk_data_checker
    import random_clk_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned VALIDATION_COUNT = 3,
    parameter int unsigned LOCK_RUNS        = 4,
    parameter int unsigned ERR_CNT_WIDTH    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_WIDTH-1:0]    i_Data,
    output logic                     o_Locked,
    output logic                     o_Error,
    output logic [ERR_CNT_WIDTH-1:0] o_Error_Count,
    output logic                     o_Fault
);

    localparam int unsigned       GOOD_W    = $clog2(LOCK_RUNS + 1);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_RUNS - 1);

    checker_state_e            state;
    checker_state_e            state_d;
    logic [GOOD_W-1:0]         r_good;
    logic [GOOD_W-1:0]         good_d;
    logic                      err_d;
    logic [ERR_CNT_WIDTH-1:0]  cnt_d;
    logic [ERR_CNT_WIDTH-1:0]  cnt_inc;
    logic                      good_transition;
    logic                      bad_transition;
    logic                      run_len_ok;
    logic                      stuck;
    logic                      violation;
    logic                      good_run;

    seq_run_tracker #(
        .DATA_WIDTH       (DATA_WIDTH),
        .VALIDATION_COUNT (VALIDATION_COUNT)
    ) u_tracker (
        .clk             (clk),
        .rst             (rst),
        .data            (i_Data),
        .good_transition (good_transition),
        .bad_transition  (bad_transition),
        .run_len_ok      (run_len_ok),
        .stuck           (stuck)
    );

    // Next-state, good-run and error-count logic.
    always_comb begin
        state_d   = state;
        good_d    = r_good;
        err_d     = 1'b0;
        cnt_d     = o_Error_Count;
        cnt_inc   = (o_Error_Count == '1) ? o_Error_Count : o_Error_Count + ERR_CNT_WIDTH'(1);
        violation = bad_transition || (good_transition && !run_len_ok) || stuck;
        good_run  = good_transition && run_len_ok;

        unique case (state)
            ACQUIRE: begin
                // First run after acquisition is partial, so its length is not checked.
                if (good_transition) begin
                    state_d = SYNC;
                    good_d  = '0;
                end
            end
            SYNC: begin
                // A violation wins over a lock that would complete on the same sample.
                if (violation) begin
                    state_d = ACQUIRE;
                end else if (good_run) begin
                    good_d = r_good + GOOD_W'(1);
                    if (r_good == GOOD_LAST) begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (violation) begin
                    err_d = 1'b1;
                    cnt_d = cnt_inc;
`ifdef CHECKER_STICKY_FAULT_EN
                    state_d = FAULT;
`else
                    state_d = ACQUIRE;
`endif
                end
            end
`ifdef CHECKER_STICKY_FAULT_EN
            FAULT: begin
                if (violation) begin
                    err_d = 1'b1;
                    cnt_d = cnt_inc;
                end
            end
`endif
            default: begin
                state_d = ACQUIRE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ACQUIRE;
            r_good        <= '0;
            o_Locked      <= 1'b0;
            o_Error       <= 1'b0;
            o_Error_Count <= '0;
        end else begin
            state         <= state_d;
            r_good        <= good_d;
            o_Locked      <= (state_d == LOCKED);
            o_Error       <= err_d;
            o_Error_Count <= cnt_d;
        end
    end

`ifdef CHECKER_STICKY_FAULT_EN
    // Sticky fault flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_Fault <= 1'b0;
        end else begin
            o_Fault <= (state_d == FAULT);
        end
    end
`else
    assign o_Fault = 1'b0;
`endif

endmodule
